fb_shift_reader: RTL and testbench

//   Read side of the asymmetric frame-buffer dual-port RAM: a 16-bit read port
//   (B) behind an 8-bit write port (A). On a start pulse it walks port B from

---
 rtl/fb_shift_reader.sv | 133 +++++++++++++
 tb/tb_fb_shift_reader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fb_shift_reader.sv
// Frame-buffer read side: walks RAM port B and shifts each word MSB-first
// onto an LED driver chain, then strobes latch and reports done.
module fb_shift_reader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int WORDS  = 256,
    parameter int CLKDIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              sclk,
    output logic              sdata,
    output logic              latch,
    output logic              busy,
    output logic              done
);

    localparam int DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLKDIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SHIFT,
        S_LATCH,
        S_DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [DIV_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic               phase;
    logic [DATA_W-1:0]  shreg;
    logic               div_end;
    logic               word_end;

    assign div_end  = (div_cnt == DIV_LAST);
    assign word_end = div_end && phase && (bit_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: state_d = S_LOAD;
            S_LOAD:  state_d = S_SHIFT;
            S_SHIFT: begin
                if (word_end) begin
                    if (ram_addr == ADDR_LAST) state_d = S_LATCH;
                    else                       state_d = S_FETCH;
                end
            end
            S_LATCH: if (div_end) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ram_addr doubles as the word counter; it parks on the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            phase    <= 1'b0;
            shreg    <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) ram_addr <= '0;
                    div_cnt <= '0;
                    phase   <= 1'b0;
                end
                S_LOAD: begin
                    shreg   <= ram_dout;
                    bit_cnt <= BIT_LAST;
                    div_cnt <= '0;
                    phase   <= 1'b0;
                end
                S_SHIFT: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        phase   <= ~phase;
                        if (phase) begin
                            if (bit_cnt == '0) begin
                                if (ram_addr != ADDR_LAST)
                                    ram_addr <= ram_addr + ADDR_W'(1);
                            end else begin
                                bit_cnt <= bit_cnt - BIT_W'(1);
                                shreg   <= shreg << 1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                S_LATCH: begin
                    if (div_end) div_cnt <= '0;
                    else         div_cnt <= div_cnt + DIV_W'(1);
                end
                default: begin
                    div_cnt <= '0;
                    phase   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        busy  = (state_q != S_IDLE);
        sclk  = (state_q == S_SHIFT) && phase;
        sdata = (state_q == S_SHIFT) && shreg[DATA_W-1];
        latch = (state_q == S_LATCH);
        done  = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_fb_shift_reader.sv
// Bench for fb_shift_reader: four instances with different WORDS/CLKDIV,
// each behind a 1-clk registered RAM model, checked against a frame model.
module tb_fb_shift_reader;

    localparam int NI = 4;
    localparam int WT[NI] = '{4, 2, 1, 256};
    localparam int DT[NI] = '{1, 3, 2, 1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  start;
    logic [7:0]  addr [NI];
    logic [15:0] dout [NI];
    logic [3:0]  sclk, sdata, latch, busy, done;
    logic [15:0] mem [NI][256];

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    fb_shift_reader #(.ADDR_W(8), .DATA_W(16), .WORDS(4), .CLKDIV(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .ram_addr(addr[0]),
        .ram_dout(dout[0]), .sclk(sclk[0]), .sdata(sdata[0]),
        .latch(latch[0]), .busy(busy[0]), .done(done[0]));
    fb_shift_reader #(.ADDR_W(8), .DATA_W(16), .WORDS(2), .CLKDIV(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .ram_addr(addr[1]),
        .ram_dout(dout[1]), .sclk(sclk[1]), .sdata(sdata[1]),
        .latch(latch[1]), .busy(busy[1]), .done(done[1]));
    fb_shift_reader #(.ADDR_W(8), .DATA_W(16), .WORDS(1), .CLKDIV(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .ram_addr(addr[2]),
        .ram_dout(dout[2]), .sclk(sclk[2]), .sdata(sdata[2]),
        .latch(latch[2]), .busy(busy[2]), .done(done[2]));
    fb_shift_reader #(.ADDR_W(8), .DATA_W(16), .WORDS(256), .CLKDIV(1)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start[3]), .ram_addr(addr[3]),
        .ram_dout(dout[3]), .sclk(sclk[3]), .sdata(sdata[3]),
        .latch(latch[3]), .busy(busy[3]), .done(done[3]));

    always @(posedge clk)
        for (int k = 0; k < NI; k++) dout[k] <= mem[k][addr[k]];

    // Monitor state, sampled on the falling edge.
    bit   bits_q  [NI][$];
    int   addrs_q [NI][$];
    int   runs_q  [NI][$];
    int   at_latch[NI], latch_clks[NI], latch_runs[NI], done_clks[NI];
    int   bad_hi[NI], bad_hiw[NI], bad_idle[NI], bad_done[NI];
    int   busy_run[NI], hi_run[NI];
    logic p_sclk[NI], p_sdata[NI], p_latch[NI], p_busy[NI], p_done[NI];
    logic [7:0] p_addr[NI];

    task automatic mon(int k);
        if (sclk[k] && !p_sclk[k]) bits_q[k].push_back(sdata[k]);
        if (sclk[k] && p_sclk[k] && sdata[k] != p_sdata[k]) bad_hi[k]++;
        if (sclk[k]) hi_run[k]++;
        else if (p_sclk[k]) begin
            if (hi_run[k] != DT[k]) bad_hiw[k]++;
            hi_run[k] = 0;
        end
        if (latch[k]) begin
            latch_clks[k]++;
            if (!p_latch[k]) begin
                latch_runs[k]++;
                at_latch[k] = bits_q[k].size();
            end
        end
        if ((!busy[k] || latch[k]) && (sclk[k] || sdata[k])) bad_idle[k]++;
        if (!busy[k] && (latch[k] || done[k])) bad_idle[k]++;
        if (done[k]) done_clks[k]++;
        if (p_done[k] && busy[k]) bad_done[k]++;
        if (busy[k] && (!p_busy[k] || addr[k] != p_addr[k]))
            addrs_q[k].push_back(int'(addr[k]));
        if (busy[k]) busy_run[k]++;
        else if (p_busy[k]) begin
            runs_q[k].push_back(busy_run[k]);
            busy_run[k] = 0;
        end
        p_sclk[k]  = sclk[k];
        p_sdata[k] = sdata[k];
        p_latch[k] = latch[k];
        p_busy[k]  = busy[k];
        p_done[k]  = done[k];
        p_addr[k]  = addr[k];
    endtask

    always @(negedge clk)
        for (int k = 0; k < NI; k++) mon(k);

    task automatic clr(int k);
        bits_q[k].delete();
        addrs_q[k].delete();
        runs_q[k].delete();
        at_latch[k] = 0; latch_clks[k] = 0; latch_runs[k] = 0;
        done_clks[k] = 0; bad_hi[k] = 0; bad_hiw[k] = 0;
        bad_idle[k] = 0; bad_done[k] = 0; busy_run[k] = 0; hi_run[k] = 0;
    endtask

    task automatic chk(string tag, longint obs, longint exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint outs(int k);
        return longint'({addr[k], sclk[k], sdata[k], latch[k], busy[k], done[k]});
    endfunction

    // Start a frame on instance k, holding start for 'hold' clocks.
    task automatic run(int k, int hold);
        int t;
        @(posedge clk);
        clr(k);
        @(negedge clk);
        start[k] = 1'b1;
        chk($sformatf("busy_before_start%0d", k), busy[k], 0);
        @(negedge clk);
        chk($sformatf("busy_latency%0d", k), busy[k], 1);
        repeat (hold - 1) @(negedge clk);
        start[k] = 1'b0;
        t = 0;
        while (busy[k] && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("frame_timeout%0d", k), busy[k], 0);
        repeat (2) @(negedge clk);
    endtask

    // Compare a completed run of nf frames against the frame model.
    task automatic check(int k, int nf);
        int w, d, nbad, nbit, blen;
        logic [15:0] ow;
        w    = WT[k];
        d    = DT[k];
        nbit = nf * w * 16;
        blen = w * (2 + 2 * 16 * d) + d + 1;
        chk($sformatf("edges%0d", k), bits_q[k].size(), nbit);
        nbad = 0;
        if (bits_q[k].size() == nbit)
            for (int i = 0; i < nf * w; i++) begin
                ow = '0;
                for (int j = 0; j < 16; j++) ow = {ow[14:0], bits_q[k][16*i+j]};
                if (ow !== mem[k][i % w]) nbad++;
            end
        chk($sformatf("bad_words%0d", k), nbad, 0);
        chk($sformatf("frames%0d", k), runs_q[k].size(), nf);
        foreach (runs_q[k][i]) chk($sformatf("busy_len%0d", k), runs_q[k][i], blen);
        chk($sformatf("latch_runs%0d", k), latch_runs[k], nf);
        chk($sformatf("latch_clks%0d", k), latch_clks[k], nf * d);
        chk($sformatf("latch_after_edges%0d", k), at_latch[k], nbit);
        chk($sformatf("done_clks%0d", k), done_clks[k], nf);
        chk($sformatf("done_not_last%0d", k), bad_done[k], 0);
        chk($sformatf("sdata_hi_toggle%0d", k), bad_hi[k], 0);
        chk($sformatf("sclk_hi_width%0d", k), bad_hiw[k], 0);
        chk($sformatf("idle_outputs%0d", k), bad_idle[k], 0);
        chk($sformatf("addr_count%0d", k), addrs_q[k].size(), nf * w);
        nbad = 0;
        foreach (addrs_q[k][i]) if (addrs_q[k][i] != i % w) nbad++;
        chk($sformatf("addr_seq%0d", k), nbad, 0);
    endtask

    initial begin
        int t, nf;
        rst_n = 1'b0;
        start = '0;
        for (int k = 0; k < NI; k++) begin
            for (int a = 0; a < 256; a++) mem[k][a] = 16'($urandom);
            p_sclk[k] = 0; p_sdata[k] = 0; p_latch[k] = 0;
            p_busy[k] = 0; p_done[k] = 0; p_addr[k] = '0;
            clr(k);
        end
        mem[0][0] = 16'hA5C3;
        mem[0][1] = 16'h0001;
        mem[0][2] = 16'h8000;
        mem[0][3] = 16'hFFFF;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) chk($sformatf("reset_outs%0d", k), outs(k), 0);
        rst_n = 1'b1;

        // Directed frame with known words.
        run(0, 1);
        check(0, 1);

        // Start held high: frames repeat with one idle clock between them.
        for (int a = 0; a < 4; a++) mem[0][a] = 16'($urandom);
        run(0, 300);
        nf = (300 - 1) / (WT[0] * (2 + 32 * DT[0]) + DT[0] + 2) + 1;
        check(0, nf);

        // Reset in the middle of word 2, bit 5.
        @(posedge clk);
        clr(0);
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        t = 0;
        while (bits_q[0].size() < 37 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("abort_reach", bits_q[0].size(), 37);
        #1 rst_n = 1'b0;
        #1 chk("abort_outs", outs(0), 0);
        repeat (3) @(negedge clk);
        chk("abort_latch", latch_runs[0], 0);
        rst_n = 1'b1;
        for (int a = 0; a < 4; a++) mem[0][a] = 16'($urandom);
        run(0, 1);
        check(0, 1);

        // CLKDIV=3, WORDS=1 and WORDS=256 instances.
        for (int k = 1; k < NI; k++) begin
            run(k, 1);
            check(k, 1);
        end
        chk("addr_parked255", addr[3], 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
